keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner and debouncer that replaces the fixed 4x4 scanner. It drives one active-low row at a time and samples active-low columns after a settle delay. Each full scan is reduced to a frame result (none, single key, or multiple keys), and debouncing is done across whole frames. Outputs are a registered key code, a one-cycle press strobe, a release strobe, held and multi-key levels, and the code feeds the seven-segment display path.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_debounce.sv | 143 ++++++++++++++
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the matrix keypad scanner.
//   - debounce FSM state encoding (legacy-compatible localparam constants)
//   - frame result enumeration produced by the scan engine each full scan
//   - clog2 helper used to size counters and the key code
package keypad_pkg;

  // Debounce FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_PRESS_CHK   = 2'd1;
  localparam state_t ST_HELD        = 2'd2;
  localparam state_t ST_RELEASE_CHK = 2'd3;

  // Outcome of one complete scan of all rows
  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_result_e;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce FSM for the keypad scanner.
// A press or release is accepted only after DEBOUNCE consecutive identical
// frame results. No rollover: once a key is held, a full release is needed
// before another key can be accepted.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        low parks the FSM in idle and suppresses strobes
//   frame_done    one-cycle pulse at the end of each full scan
//   frame_result  NONE / SINGLE / MULTI for the frame just finished
//   frame_code    code of the first key seen in that frame
//   key_code      last accepted key (held across release)
//   key_valid     one-cycle pulse on accepted press
//   key_release   one-cycle pulse on accepted release
//   key_held      high while an accepted key is down
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned KEY_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             frame_done,
  input  logic [1:0]       frame_result,
  input  logic [KEY_W-1:0] frame_code,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_held
);

  localparam int unsigned    CNT_W   = clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             release_q, release_d;

  logic is_none;
  logic is_single;
  logic cnt_reached;

  assign is_none     = (frame_result == FR_NONE);
  assign is_single   = (frame_result == FR_SINGLE);
  // The current frame would be the DEBOUNCE-th consecutive match
  assign cnt_reached = ((cnt_q + CNT_ONE) == DEB_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    release_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_HELD;
              code_d  = frame_code;
              valid_d = 1'b1;
            end else begin
              state_d = ST_PRESS_CHK;
              cand_d  = frame_code;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!is_single) begin
            state_d = ST_IDLE;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end else if (cnt_reached) begin
            state_d = ST_HELD;
            code_d  = cand_q;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            if (DEBOUNCE == 1) begin
              state_d   = ST_IDLE;
              release_d = 1'b1;
            end else begin
              state_d = ST_RELEASE_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (!is_none) begin
            state_d = ST_HELD;
          end else if (cnt_reached) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      release_q <= release_d;
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_release = release_q;
  // Still held while a release is being confirmed
  assign key_held    = (state_q == ST_HELD) || (state_q == ST_RELEASE_CHK);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix keypad scanner with frame debouncing.
// Drives one active-low row at a time for SCAN_DIV clocks, samples the
// synchronised active-low columns SETTLE clocks into each row, reduces a full
// scan to NONE / SINGLE / MULTI and hands that to keypad_debounce.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        scan enable; low parks the scanner at row 0, rows released
//   col_i         raw active-low column inputs (asynchronous)
//   row_o         registered one-cold active-low row drive
//   key_code      last accepted key, row_idx*COLS+col_idx
//   key_valid     one-cycle pulse on accepted press
//   key_release   one-cycle pulse on accepted release
//   key_held      high while an accepted key is down
//   multi_key     high if the last completed frame saw two or more keys
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned SETTLE   = 10,
  parameter int unsigned DEBOUNCE = 4,
  localparam int unsigned KEY_W   = clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [COLS-1:0]  col_i,
  output logic [ROWS-1:0]  row_o,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_held,
  output logic             multi_key
);

  localparam int unsigned TIMER_W = clog2(SCAN_DIV);
  localparam int unsigned ROW_W   = clog2(ROWS);
  localparam int unsigned COL_W   = clog2(COLS);

  localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(SCAN_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAMPLE = TIMER_W'(SETTLE);
  localparam logic [ROW_W-1:0]   ROW_LAST     = ROW_W'(ROWS - 1);

  logic [COLS-1:0]    col_meta_q, col_sync_q;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [ROWS-1:0]    row_q, row_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0]   acc_code_q, acc_code_d;
  logic               multi_q, multi_d;

  logic               timer_wrap;
  logic               sample;
  logic               frame_done;
  logic [1:0]         row_low_cnt;
  logic [COL_W-1:0]   row_col;
  logic [KEY_W-1:0]   row_code;
  logic [2:0]         acc_sum;
  frame_result_e      frame_result;

  assign timer_wrap = (timer_q == TIMER_LAST);
  assign sample     = enable && (timer_q == TIMER_SAMPLE);
  assign frame_done = enable && timer_wrap && (row_idx_q == ROW_LAST);

  // Per-row decode: count of low columns (saturating at 2) and the lowest one
  always_comb begin
    row_low_cnt = 2'd0;
    row_col     = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_sync_q[c]) begin
        row_col = COL_W'(c);
        if (row_low_cnt != 2'd2) row_low_cnt = row_low_cnt + 2'd1;
      end
    end
  end

  assign row_code = KEY_W'(32'(row_idx_q) * COLS + 32'(row_col));

  // Timer, row index and row drive
  always_comb begin
    timer_d   = timer_q;
    row_idx_d = row_idx_q;
    row_d     = row_q;
    if (!enable) begin
      timer_d   = '0;
      row_idx_d = '0;
      row_d     = '1;
    end else begin
      row_d = ~(ROWS'(1) << row_idx_q);
      if (timer_wrap) begin
        timer_d   = '0;
        row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  // Frame accumulators; sampling never coincides with a frame end because
  // the sample point sits at least two clocks before the timer wraps.
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    multi_d    = multi_q;
    acc_sum    = {1'b0, acc_cnt_q} + {1'b0, row_low_cnt};
    if (!enable || frame_done) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = '0;
    end else if (sample && (row_low_cnt != 2'd0)) begin
      if (acc_cnt_q == 2'd0) acc_code_d = row_code;
      acc_cnt_d = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    end
    if (frame_done) multi_d = (acc_cnt_q == 2'd2);
  end

  always_comb begin
    unique case (acc_cnt_q)
      2'd0:    frame_result = FR_NONE;
      2'd1:    frame_result = FR_SINGLE;
      default: frame_result = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      timer_q    <= '0;
      row_idx_q  <= '0;
      row_q      <= '1;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= '0;
      multi_q    <= 1'b0;
    end else begin
      col_meta_q <= col_i;
      col_sync_q <= col_meta_q;
      timer_q    <= timer_d;
      row_idx_q  <= row_idx_d;
      row_q      <= row_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      multi_q    <= multi_d;
    end
  end

  assign row_o     = row_q;
  assign multi_key = multi_q;

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .KEY_W    (KEY_W)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (acc_code_q),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_release  (key_release),
    .key_held     (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
// Instance A is 4x4 (randomised key sets vs. a frame-level reference model),
// instance B is 3x5 (code mapping, row sequence and enable behaviour).
module tb_keypad_scanner;

  localparam int SD      = 16;
  localparam int DEB     = 3;
  localparam int FRAME_A = 4 * SD;
  localparam int FRAME_B = 3 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1;
  logic en_b = 1'b0;

  logic [3:0]  col_a, row_a, code_a;
  logic        valid_a, rel_a, held_a, multi_a;
  logic [4:0]  col_b;
  logic [2:0]  row_b;
  logic [3:0]  code_b;
  logic        valid_b, rel_b, held_b, multi_b;

  logic [15:0] keys_a = '0;
  logic [14:0] keys_b = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_a    = 0;

  // Frame-level reference model state
  bit         m_held, m_multi, m_valid, m_release;
  int         m_run_code, m_run_len, m_rel_len;
  logic [3:0] m_code;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .SETTLE(4), .DEBOUNCE(DEB)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .col_i(col_a), .row_o(row_a),
    .key_code(code_a), .key_valid(valid_a), .key_release(rel_a),
    .key_held(held_a), .multi_key(multi_a)
  );

  keypad_scanner #(
    .ROWS(3), .COLS(5), .SCAN_DIV(SD), .SETTLE(4), .DEBOUNCE(DEB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .col_i(col_b), .row_o(row_b),
    .key_code(code_b), .key_valid(valid_b), .key_release(rel_b),
    .key_held(held_b), .multi_key(multi_b)
  );

  // Physical keypads: a pressed key shorts its row line to its column line
  always_comb begin
    col_a = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_a[r] && keys_a[r*4+c]) col_a[c] = 1'b0;
  end

  always_comb begin
    col_b = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (!row_b[r] && keys_b[r*5+c]) col_b[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Row k clocks after scan start: row (k-1)/SD is driven, all released at k=0
  function automatic logic [3:0] exp_row_a(input int k);
    if (k == 0) return 4'hF;
    return ~(4'b0001 << (((k - 1) / SD) % 4));
  endfunction

  function automatic logic [2:0] exp_row_b(input int k);
    if (k == 0) return 3'b111;
    return ~(3'b001 << (((k - 1) / SD) % 3));
  endfunction

  task automatic model_reset();
    m_held = 0; m_multi = 0; m_valid = 0; m_release = 0;
    m_run_code = 0; m_run_len = 0; m_rel_len = 0; m_code = '0;
  endtask

  // Debounce expressed as run lengths of identical frames
  task automatic model_frame(input logic [15:0] keys);
    int n;
    int c;
    n = $countones(keys);
    c = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) c = i;
    m_multi = (n >= 2);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run_len > 0 && c == m_run_code) m_run_len++;
        else begin
          m_run_code = c;
          m_run_len  = 1;
        end
        if (m_run_len == DEB) begin
          m_held    = 1;
          m_code    = 4'(c);
          m_valid   = 1;
          m_run_len = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel_len++;
        if (m_rel_len == DEB) begin
          m_held    = 0;
          m_release = 1;
          m_rel_len = 0;
        end
      end else begin
        m_rel_len = 0;
      end
    end
  endtask

  task automatic tick_a();
    @(posedge clk);
    cyc_a++;
    m_valid   = 0;
    m_release = 0;
    if (cyc_a % FRAME_A == 0) model_frame(keys_a);
    @(negedge clk);
    check("row_a", row_a, exp_row_a(cyc_a));
    check("key_valid_a", valid_a, m_valid);
    check("key_release_a", rel_a, m_release);
    check("key_held_a", held_a, m_held);
    check("multi_key_a", multi_a, m_multi);
    check("key_code_a", code_a, m_code);
  endtask

  // Hold a key set for whole frames; called only on frame boundaries
  task automatic run_a(input logic [15:0] keys, input int frames);
    keys_a = keys;
    repeat (frames * FRAME_A) tick_a();
  endtask

  task automatic run_b_press();
    keys_b = 15'h4000;  // row 2, col 4
    en_b   = 1'b1;
    for (int k = 1; k <= 3 * FRAME_B + 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("row_b", row_b, exp_row_b(k));
      check("key_valid_b", valid_b, (k == 3 * FRAME_B));
      check("key_release_b", rel_b, 0);
      check("key_held_b", held_b, (k >= 3 * FRAME_B));
    end
    check("key_code_b", code_b, 14);
  endtask

  initial begin
    logic [15:0] keys;
    int          sticky;
    int          a;
    int          b;

    model_reset();
    @(negedge clk);
    check("rst_row_a", row_a, 4'hF);
    check("rst_row_b", row_b, 3'b111);
    check("rst_code_a", code_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_held_a", held_a, 0);
    check("rst_multi_a", multi_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_a = 0;

    // Steady key 9, then a short release and a full release
    run_a(16'h0200, 4);
    check("press9_code", code_a, 9);
    check("press9_held", held_a, 1);
    run_a(16'h0000, 2);
    run_a(16'h0200, 1);
    check("bounce_release_held", held_a, 1);
    run_a(16'h0000, 3);
    check("release9_code", code_a, 9);
    check("release9_held", held_a, 0);

    // Intermittent key never accepted
    run_a(16'h0200, 1);
    run_a(16'h0000, 1);
    run_a(16'h0200, 1);
    run_a(16'h0000, 1);
    check("glitch_held", held_a, 0);

    // Two keys then one of them
    run_a(16'h8001, 4);
    check("multi_level", multi_a, 1);
    check("multi_held", held_a, 0);
    run_a(16'h0001, 3);
    check("multi_then_code", code_a, 0);
    check("multi_then_flag", multi_a, 0);
    run_a(16'h0000, 3);

    // Randomised key sets
    sticky = 5;
    for (int f = 0; f < 40; f++) begin
      a    = $urandom_range(0, 9);
      keys = '0;
      if (a >= 3 && a <= 6) keys[sticky] = 1'b1;
      else if (a == 7 || a == 8) begin
        sticky = $urandom_range(0, 15);
        keys[sticky] = 1'b1;
      end else if (a == 9) begin
        b = $urandom_range(0, 15);
        keys[b] = 1'b1;
        keys[(b + $urandom_range(1, 15)) % 16] = 1'b1;
      end
      run_a(keys, $urandom_range(1, 4));
    end

    // Reset mid-frame with a key held
    run_a(16'h0000, 3);
    run_a(16'h0020, 3);
    check("pre_reset_held", held_a, 1);
    repeat (20) tick_a();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_row", row_a, 4'hF);
    check("async_rst_held", held_a, 0);
    check("async_rst_code", code_a, 0);
    check("async_rst_valid", valid_a, 0);
    check("async_rst_multi", multi_a, 0);
    @(negedge clk);
    @(negedge clk);
    check("in_rst_release", rel_a, 0);
    rst_n = 1'b1;
    cyc_a = 0;
    model_reset();
    run_a(16'h0020, 3);
    check("after_rst_code", code_a, 5);
    run_a(16'h0000, 3);

    // 3x5 instance: code mapping, row order, enable park and restart
    check("parked_row_b", row_b, 3'b111);
    run_b_press();
    en_b = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("dis_row_b", row_b, 3'b111);
      check("dis_held_b", held_b, 0);
      check("dis_valid_b", valid_b, 0);
      check("dis_release_b", rel_b, 0);
      check("dis_code_b", code_b, 14);
    end
    run_b_press();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
